cdb_arbiter: RTL

Arbiter for the shared Common Data Bus (CDB) of the Tomasulo core. Execution units (ALU, branch unit, load/store unit) each present a finished result with its ROB tag. The block grants at most one per cycle and broadcasts the winner from a registered output stage to the ROB and all reservation stations. A flush input discards arbitration on branch mispredict, and unit-side handshakes give the front-end stall logic a per-unit "result accepted" signal.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_picker.sv | 31 +++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default tag/data widths and the
// requester index assignment of the execution units.
package cdb_arbiter_pkg;

  // Default ROB tag and result widths used as parameter defaults.
  localparam int CDB_TAG_W  = 3;
  localparam int CDB_DATA_W = 32;

  // Requester index of each execution unit on the CDB.
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_BRA = 1;
  localparam int CDB_SRC_LSM = 2;

  // Width of a requester index for n units.
  function automatic int cdb_src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational picker. Scans the valid mask starting at start_i,
// wrapping modulo NUM_REQ, and returns a one-hot grant plus its index.
// A start pointer of zero gives plain fixed (lowest index first) priority.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [SRC_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   idx_o
);

  // First valid requester at or after start_i, wrapping around.
  always_comb begin
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && valid_i[i] && (((int'(start_i) + k) % NUM_REQ) == i)) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = SRC_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants at most one finished result per cycle onto the Common
// Data Bus and broadcasts it from a registered output stage.
// Build option: CDB_RR_EN selects round-robin picking (with a rotating start
// pointer); when undefined the lowest valid index always wins.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SRC_W-1:0]            cdb_src,
  output logic                        cdb_conflict
);

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   start;
  logic               any_grant;
  logic [TAG_W-1:0]   tag_sel;
  logic [DATA_W-1:0]  data_sel;

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
  logic               cdb_conflict_q, cdb_conflict_d;

`ifdef CDB_RR_EN
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_picker (
    .valid_i (req_valid),
    .start_i (start),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Grants are suppressed entirely during reset and flush cycles.
  assign req_ready = (rst || flush) ? '0 : grant;
  assign any_grant = |req_ready;

  // Select the winner's tag and data; the grant is one-hot so OR-ing is safe.
  always_comb begin
    tag_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        tag_sel  = tag_sel  | req_tag[i*TAG_W +: TAG_W];
        data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state of the broadcast stage; payload holds when nothing transfers.
  always_comb begin
    cdb_valid_d    = any_grant;
    cdb_tag_d      = cdb_tag_q;
    cdb_data_d     = cdb_data_q;
    cdb_src_d      = cdb_src_q;
    cdb_conflict_d = ($countones(req_valid) > 1) && !flush;
    if (any_grant) begin
      cdb_tag_d  = tag_sel;
      cdb_data_d = data_sel;
      cdb_src_d  = grant_idx;
    end
  end

`ifdef CDB_RR_EN
  // Rotate the scan start past the last winner; flush restarts at the ALU.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = SRC_W'(CDB_SRC_ALU);
    end else if (any_grant) begin
      if (int'(grant_idx) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SRC_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SRC_W'(CDB_SRC_ALU);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Broadcast output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= '0;
      cdb_conflict_q <= 1'b0;
    end else begin
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      cdb_src_q      <= cdb_src_d;
      cdb_conflict_q <= cdb_conflict_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign cdb_conflict = cdb_conflict_q;

endmodule
